// File: rtl/bcd_ascii_streamer_pkg.sv
// bcd_ascii_streamer_pkg: shared state encoding, ASCII constants and default digit count
package bcd_ascii_streamer_pkg;
    typedef enum logic [2:0] {IDLE, SKIP, SEND, CR, LF, REARM} state_t;
    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_ERR = 8'h3F;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam int DEF_NUM_DIGITS = 7;
endpackage

// File: rtl/bcd_ascii_streamer_if.sv
// bcd_ascii_streamer_if: BCD capture inputs and ASCII byte-stream handshake
interface bcd_ascii_streamer_if import bcd_ascii_streamer_pkg::*; #(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic bcd_valid;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic busy;
    logic done;
    logic digit_err;
    modport master (output bcd_in, bcd_valid, tx_ready, input tx_data, tx_valid, busy, done, digit_err);
    modport slave (input bcd_in, bcd_valid, tx_ready, output tx_data, tx_valid, busy, done, digit_err);
endinterface

// File: rtl/bcd_digit_to_ascii.sv
// bcd_digit_to_ascii: maps one BCD nibble to its ASCII digit, '?' for nibbles above 9
module bcd_digit_to_ascii import bcd_ascii_streamer_pkg::*; (
    input  logic [3:0] i_digit,
    output logic [7:0] o_ascii,
    output logic       o_err
);
    assign o_err = i_digit > 4'd9;
    assign o_ascii = o_err ? ASC_ERR : ASC_ZERO + {4'd0, i_digit};
endmodule

// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer: streams a captured packed BCD value as ASCII bytes with optional CR/LF
module bcd_ascii_streamer import bcd_ascii_streamer_pkg::*; #(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit APPEND_CRLF = 1'b1
) (
    input logic clk,
    input logic reset,
    bcd_ascii_streamer_if.slave bus
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    state_t r_state, w_next;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [IW-1:0] r_idx;
    logic r_err, r_done;
    logic [3:0] w_digit;
    logic [7:0] w_ascii;
    logic w_bad, w_capture, w_skip, w_xfer, w_last, w_dec, w_idx_zero;
    assign w_digit = 4'(r_bcd >> {r_idx, 2'b00});
    bcd_digit_to_ascii u_map (.i_digit(w_digit), .o_ascii(w_ascii), .o_err(w_bad));
    assign w_idx_zero = r_idx == '0;
    assign w_capture = r_state == IDLE && bus.bcd_valid;
    assign w_skip = SUPPRESS_ZEROS && r_state == SKIP && w_digit == 4'd0 && !w_idx_zero;
    assign bus.tx_valid = r_state inside {SEND, CR, LF};
    assign w_xfer = bus.tx_valid && bus.tx_ready;
    assign w_last = w_xfer && (r_state == LF || (r_state == SEND && w_idx_zero && !APPEND_CRLF));
    assign w_dec = w_skip || (r_state == SEND && w_xfer && !w_idx_zero);
    assign bus.tx_data = r_state == SEND ? w_ascii : r_state == CR ? ASC_CR : r_state == LF ? ASC_LF : 8'h00;
    assign bus.busy = !(r_state inside {IDLE, REARM});
    assign bus.done = r_done;
    assign bus.digit_err = r_err;
    // next-state selection; bytes only advance on an accepted handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.bcd_valid ? SKIP : IDLE;
            SKIP:    w_next = w_skip ? SKIP : SEND;
            SEND:    w_next = !w_xfer || !w_idx_zero ? SEND : APPEND_CRLF ? CR : REARM;
            CR:      w_next = w_xfer ? LF : CR;
            LF:      w_next = w_xfer ? REARM : LF;
            REARM:   w_next = bus.bcd_valid ? REARM : IDLE;
            default: w_next = IDLE;
        endcase
    end
    // state, captured value, digit index, sticky error and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bcd <= '0;
            r_idx <= '0;
            r_err <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done <= w_last;
            if (w_capture) begin
                r_bcd <= bus.bcd_in;
                r_idx <= LAST_IDX;
                r_err <= 1'b0;
            end else begin
                if (w_dec) r_idx <= r_idx - IW'(1);
                if (r_state == SEND && w_bad) r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bcd_ascii_streamer.sv
// tb_bcd_ascii_streamer: scoreboard bench with a digit-string reference model and random traffic
module tb_bcd_ascii_streamer;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    int pop_cnt = 0;
    int ready_mode = 0;
    logic [8:0] exp_q[$];

    bcd_ascii_streamer_if #(.NUM_DIGITS(7)) bus ();
    bcd_ascii_streamer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: the value as a 7-character digit string, leading '0's dropped except the last
    task automatic issue(input logic [27:0] v, output logic err);
        int d[7];
        int val;
        int k;
        val = int'(v);
        err = 1'b0;
        for (int i = 0; i < 7; i++) begin
            d[i] = (val / (16 ** (6 - i))) % 16;
            if (d[i] > 9) err = 1'b1;
        end
        k = 0;
        while (k < 6 && d[k] == 0) k++;
        for (int i = k; i < 7; i++)
            exp_q.push_back({1'b0, d[i] > 9 ? 8'h3F : 8'(48 + d[i])});
        exp_q.push_back({1'b0, 8'h0D});
        exp_q.push_back({1'b1, 8'h0A});
    endtask

    task automatic run(input logic [27:0] v, input int hold);
        logic err;
        int n;
        bus.bcd_in = v;
        bus.bcd_valid = 1'b1;
        issue(v, err);
        @(posedge clk); #1;
        chk("busy_on_capture", 32'(bus.busy), 32'd1);
        chk("err_clear_on_capture", 32'(bus.digit_err), 32'd0);
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("first_byte_latency_ok", 32'(n <= 8), 32'd1);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.bcd_valid = 1'b0;
        bus.bcd_in = 28'($urandom);
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sequence_complete", 32'(n < 400), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("digit_err", 32'(bus.digit_err), 32'(err));
    endtask

    // downstream ready pattern: always high, toggling, or random
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.tx_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~bus.tx_ready : 1'($urandom);
        end
    end

    // monitor: pops expected bytes on each handshake and checks done, stall hold and back-to-back flow
    initial begin
        logic prev_last;
        logic prev_mid;
        logic prev_stall;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_last = 1'b0;
        prev_mid = 1'b0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_last = 1'b0;
                prev_mid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                chk("done_pulse", 32'(bus.done), 32'(prev_last));
                if (prev_stall) chk("stall_hold", 32'({bus.tx_valid, bus.tx_data}), 32'({1'b1, prev_data}));
                if (prev_mid && ready_mode == 0) chk("back_to_back", 32'(bus.tx_valid), 32'd1);
                prev_last = 1'b0;
                prev_mid = 1'b0;
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte: got %0h expected no byte at %0t", bus.tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
                        prev_last = e[8];
                        prev_mid = !e[8];
                        pop_cnt++;
                    end
                end
                prev_stall = bus.tx_valid && !bus.tx_ready;
                prev_data = bus.tx_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic err;
        logic [27:0] v;
        logic [3:0] nib;
        int n;
        int base;
        int lead;
        reset = 1'b1;
        bus.bcd_valid = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_digit_err", 32'(bus.digit_err), 32'd0);
        run(28'h0000000, 0);
        run(28'h1234567, 0);
        ready_mode = 1;
        run(28'h0000042, 0);
        ready_mode = 0;
        run(28'h00000A5, 0);
        repeat (5) @(posedge clk);
        #1 chk("err_sticky", 32'(bus.digit_err), 32'd1);
        run(28'h0000000, 0);
        base = pop_cnt;
        bus.bcd_in = 28'h7654321;
        bus.bcd_valid = 1'b1;
        issue(28'h7654321, err);
        n = 0;
        while (pop_cnt < base + 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_second_byte", 32'(n < 50), 32'd1);
        reset = 1'b1;
        bus.bcd_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1 run(28'h7654321, 0);
        run(28'h9081726, 50);
        run(28'h0000305, 0);
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            lead = $urandom_range(0, 7);
            v = '0;
            for (int i = 0; i < 7; i++) begin
                nib = i < lead ? 4'd0 : ($urandom_range(0, 7) == 0 ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)));
                v = {v[23:0], nib};
            end
            run(v, $urandom_range(0, 12));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
